// File: rtl/crono_ctrl.sv
// Countdown sequencer for the chronometer timer function.
// Loads the BCD HH:MM:SS preset from the editor, counts it down on each
// 1 Hz tick and holds an alarm at 00:00:00 for a bounded number of ticks.
//
//  state | meaning
//  ------+---------------------------------------------------------
//  IDLE  | count tracks the preset; start button arms the countdown
//  RUN   | count decrements once per tick; 00:00:01 -> ALARM
//  PAUSE | count frozen, ticks ignored; start button resumes
//  ALARM | count held at zero; exits on button or after ALARM_TICKS
module crono_ctrl #(
    parameter int ALARM_TICKS = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       EN,
    input  logic       tick,
    input  logic       BTc,
    input  logic       BTclr,
    input  logic [7:0] HCcr,
    input  logic [7:0] MCcr,
    input  logic [7:0] SCcr,
    output logic [7:0] HRc,
    output logic [7:0] MRc,
    output logic [7:0] SRc,
    output logic       running,
    output logic       alarm,
    output logic [1:0] estado
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    // Last counter value before the timeout tick; the counter starts at 0.
    localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

    state_t      state, state_nxt;
    logic [23:0] count, count_nxt;
    logic [7:0]  alarm_cnt, alarm_cnt_nxt;
    logic        btc_ref, btclr_ref;
    logic        btc_edge, btclr_edge;
    logic [23:0] preset, count_dec;
    logic        preset_zero;

    // One-second BCD decrement over {HH,MM,SS}; tens of seconds and minutes
    // wrap to 5, every other digit wraps to 9. Zero is never decremented.
    function automatic logic [23:0] bcd_dec(input logic [23:0] v);
        logic [23:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (borrow) begin
                if (r[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = (i == 1 || i == 3) ? 4'd5 : 4'd9;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign preset      = {HCcr, MCcr, SCcr};
    assign preset_zero = (preset == 24'h000000);
    assign count_dec   = bcd_dec(count);
    assign btc_edge    = BTc & ~btc_ref;
    assign btclr_edge  = BTclr & ~btclr_ref;

    // State, count and alarm counter registers; button refs follow the levels every cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            alarm_cnt <= '0;
            btc_ref   <= 1'b0;
            btclr_ref <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            alarm_cnt <= alarm_cnt_nxt;
            btc_ref   <= BTc;
            btclr_ref <= BTclr;
        end
    end

    // Next-state and count update: EN beats cancel, cancel beats the state logic.
    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        alarm_cnt_nxt = alarm_cnt;
        if (EN) begin
            state_nxt = IDLE;
            count_nxt = preset;
        end else if (btclr_edge) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    count_nxt = preset;
                    if (btc_edge && !preset_zero) state_nxt = RUN;
                end
                RUN: begin
                    if (tick) begin
                        if (count == 24'h000001) begin
                            count_nxt     = '0;
                            alarm_cnt_nxt = '0;
                            state_nxt     = ALARM;
                        end else begin
                            count_nxt = count_dec;
                            if (btc_edge) state_nxt = PAUSE;
                        end
                    end else if (btc_edge) begin
                        state_nxt = PAUSE;
                    end
                end
                PAUSE: begin
                    if (btc_edge) state_nxt = RUN;
                end
                ALARM: begin
                    if (btc_edge) begin
                        state_nxt = IDLE;
                    end else if (tick) begin
                        if (alarm_cnt == ALARM_LAST) state_nxt = IDLE;
                        else alarm_cnt_nxt = alarm_cnt + 8'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        HRc     = count[23:16];
        MRc     = count[15:8];
        SRc     = count[7:0];
        estado  = state;
        running = (state == RUN);
        alarm   = (state == ALARM);
    end

endmodule
